// File: rtl/axis_uart_pkg.sv
// rtl/axis_uart_pkg.sv - shared widths, parity select, FSM states and parity helper for the UART receiver
package axis_uart_pkg;

    localparam int DATA_WIDTH    = 8;
    localparam int DIVIDER_WIDTH = 16;

    typedef struct packed {
        logic odd;
        logic even;
    } uart_parity_reg_t;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        WAIT
    } uart_state_e;

    // Expected parity bit on the line; odd wins when both selects are set.
    function automatic logic parity(input logic [DATA_WIDTH-1:0] data, input uart_parity_reg_t mode);
        return mode.odd ? ~(^data) : (^data);
    endfunction

endpackage

// File: rtl/axis_uart_sync.sv
// rtl/axis_uart_sync.sv - multi-flop synchronizer for the idle-high serial line, resets to 1
module axis_uart_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout
);

    logic [STAGES-1:0] chain;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chain <= '1;
        end else begin
            chain <= {chain[STAGES-2:0], din};
        end
    end

    assign dout = chain[STAGES-1];

endmodule

// File: rtl/axis_uart_rx.sv
// rtl/axis_uart_rx.sv - UART receiver with AXI-Stream byte output; AXIS_UART_RX_PARITY_EN enables the parity bit
module axis_uart_rx
    import axis_uart_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     uart_rx_i,
    input  logic [DIVIDER_WIDTH-1:0] clk_divider_i,
    input  uart_parity_reg_t         parity_i,
    output logic [DATA_WIDTH-1:0]    m_axis_tdata_o,
    output logic                     m_axis_tvalid_o,
    input  logic                     m_axis_tready_i,
    output logic                     parity_err_o,
    output logic                     frame_err_o,
    output logic                     overrun_o
);

    localparam int BIT_W = $clog2(DATA_WIDTH);

    logic                     rx_s;
    logic                     rx_prev;
    uart_state_e              state;
    uart_state_e              state_n;
    logic [DIVIDER_WIDTH-1:0] div_q;
    logic [DIVIDER_WIDTH-1:0] cnt;
    logic [BIT_W-1:0]         bit_cnt;
    logic [DATA_WIDTH-1:0]    shift_q;
    logic                     par_bad;
    logic                     tick;
    logic                     done;
    logic                     par_fail;
    logic                     frm_fail;

    axis_uart_sync #(.STAGES(SYNC_STAGES)) u_sync (
        .clk  (clk_i),
        .rst  (rst_i),
        .din  (uart_rx_i),
        .dout (rx_s)
    );

`ifdef AXIS_UART_RX_PARITY_EN
    uart_parity_reg_t par_q;
`else
    logic unused_parity;
    assign unused_parity = ^parity_i;
`endif

    // START samples at half a bit; every later sample is a full bit apart.
    assign tick = (state == START) ? (cnt == (div_q >> 1) - DIVIDER_WIDTH'(1))
                                   : (cnt == div_q - DIVIDER_WIDTH'(1));

    always_comb begin
        state_n  = state;
        done     = 1'b0;
        par_fail = 1'b0;
        frm_fail = 1'b0;
        case (state)
            IDLE:   if (rx_prev && !rx_s) state_n = START;
            START:  if (tick) state_n = rx_s ? IDLE : DATA;
            DATA: begin
                if (tick && bit_cnt == BIT_W'(DATA_WIDTH - 1)) begin
`ifdef AXIS_UART_RX_PARITY_EN
                    state_n = (par_q.odd || par_q.even) ? PARITY : STOP;
`else
                    state_n = STOP;
`endif
                end
            end
            PARITY: begin
`ifdef AXIS_UART_RX_PARITY_EN
                if (tick) begin
                    par_fail = (rx_s != parity(shift_q, par_q));
                    state_n  = STOP;
                end
`else
                state_n = IDLE;
`endif
            end
            STOP: begin
                if (tick) begin
                    if (rx_s) begin
                        done    = !par_bad;
                        state_n = IDLE;
                    end else begin
                        frm_fail = !par_bad;
                        state_n  = WAIT;
                    end
                end
            end
            WAIT:    if (rx_s) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rx_prev <= 1'b1;
            div_q   <= DIVIDER_WIDTH'(2);
            cnt     <= '0;
            bit_cnt <= '0;
            shift_q <= '0;
            par_bad <= 1'b0;
        end else begin
            rx_prev <= rx_s;
            cnt     <= (state == IDLE || tick) ? '0 : cnt + DIVIDER_WIDTH'(1);
            if (state == IDLE && rx_prev && !rx_s) begin
                div_q   <= (clk_divider_i < DIVIDER_WIDTH'(2)) ? DIVIDER_WIDTH'(2) : clk_divider_i;
                bit_cnt <= '0;
                par_bad <= 1'b0;
            end
            if (state == DATA && tick) begin
                shift_q <= {rx_s, shift_q[DATA_WIDTH-1:1]};
                bit_cnt <= bit_cnt + BIT_W'(1);
            end
            if (state == PARITY && tick) begin
                par_bad <= par_fail;
            end
        end
    end

`ifdef AXIS_UART_RX_PARITY_EN
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            par_q        <= '0;
            parity_err_o <= 1'b0;
        end else begin
            if (state == IDLE && rx_prev && !rx_s) begin
                par_q <= parity_i;
            end
            parity_err_o <= par_fail;
        end
    end
`else
    assign parity_err_o = 1'b0;
`endif

    // Single-entry output register; a handshake in the completion cycle frees the slot.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            m_axis_tdata_o  <= '0;
            m_axis_tvalid_o <= 1'b0;
            frame_err_o     <= 1'b0;
            overrun_o       <= 1'b0;
        end else begin
            frame_err_o <= frm_fail;
            overrun_o   <= done && m_axis_tvalid_o && !m_axis_tready_i;
            if (done && (!m_axis_tvalid_o || m_axis_tready_i)) begin
                m_axis_tdata_o  <= shift_q;
                m_axis_tvalid_o <= 1'b1;
            end else if (m_axis_tvalid_o && m_axis_tready_i) begin
                m_axis_tvalid_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_axis_uart_rx.sv
// tb/tb_axis_uart_rx.sv - randomized and directed bench for axis_uart_rx against a frame-level reference model
module tb_axis_uart_rx;
    import axis_uart_pkg::*;

`ifdef AXIS_UART_RX_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    logic                     clk = 1'b0;
    logic                     rst = 1'b1;
    logic                     rx  = 1'b1;
    logic [DIVIDER_WIDTH-1:0] div = 16;
    uart_parity_reg_t         par = '0;
    logic                     tready_set = 1'b1;
    logic                     rnd_ready  = 1'b0;
    logic                     rnd_bit    = 1'b1;
    logic                     tready;
    logic [DATA_WIDTH-1:0]    tdata;
    logic                     tvalid;
    logic                     perr;
    logic                     ferr;
    logic                     ovr;

    assign tready = rnd_ready ? rnd_bit : tready_set;

    axis_uart_rx #(.SYNC_STAGES(2)) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .uart_rx_i       (rx),
        .clk_divider_i   (div),
        .parity_i        (par),
        .m_axis_tdata_o  (tdata),
        .m_axis_tvalid_o (tvalid),
        .m_axis_tready_i (tready),
        .parity_err_o    (perr),
        .frame_err_o     (ferr),
        .overrun_o       (ovr)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Monitor: collects accepted beats, counts error pulses, checks stall stability.
    logic [7:0] got_q[$];
    int   n_perr = 0, n_ferr = 0, n_ovr = 0;
    logic stalled = 1'b0;
    logic [7:0] stall_data = '0;

    always @(posedge clk) begin
        #1 rnd_bit = $urandom_range(0, 1);
    end

    always @(negedge clk) begin
        if (rst) begin
            stalled <= 1'b0;
        end else begin
            if (stalled) begin
                check("hold_tvalid", 32'(tvalid), 32'd1);
                check("hold_tdata", 32'(tdata), 32'(stall_data));
            end
            if (tvalid && tready) got_q.push_back(tdata);
            n_perr     <= n_perr + int'(perr);
            n_ferr     <= n_ferr + int'(ferr);
            n_ovr      <= n_ovr + int'(ovr);
            stalled    <= tvalid && !tready;
            stall_data <= tdata;
        end
    end

    // Reference model: decides each frame's outcome from what was put on the line.
    logic [7:0] exp_q[$];
    int   e_perr = 0, e_ferr = 0, e_ovr = 0;
    bit   held = 1'b0;

    function automatic logic good_parity(input logic [7:0] d, input logic [1:0] mode);
        int ones;
        ones = $countones(d);
        if (mode[1]) return (ones % 2) == 0;
        return (ones % 2) == 1;
    endfunction

    task automatic model_frame(input logic [7:0] d, input logic [1:0] mode, input logic pbit,
                               input logic stop, input bit stall);
        logic first_after;
        if (PAR_EN && mode != 2'b00) begin
            if (pbit != good_parity(d, mode)) begin
                e_perr++;
                return;
            end
            first_after = stop;
        end else begin
            first_after = (mode != 2'b00) ? pbit : stop;
        end
        if (!first_after) begin
            e_ferr++;
            return;
        end
        if (stall && held) begin
            e_ovr++;
        end else begin
            exp_q.push_back(d);
            held = stall;
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic [1:0] mode, input logic pbit,
                              input logic stop, input int low_extra);
        int bt;
        bt = (div < 2) ? 2 : int'(div);
        rx = 1'b0;
        step(bt);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            step(bt);
        end
        if (mode != 2'b00) begin
            rx = pbit;
            step(bt);
        end
        rx = stop;
        step(bt);
        if (!stop) begin
            step(low_extra);
            check("wait_state", 32'(dut.state), 32'(WAIT));
            rx = 1'b1;
            step(6);
            check("wait_exit", 32'(dut.state), 32'(IDLE));
        end
        rx = 1'b1;
        step(2 * bt);
    endtask

    task automatic verify(input string tag);
        for (int i = 0; i < 300 && got_q.size() < exp_q.size(); i++) step(1);
        step(4);
        check({tag, "_beats"}, 32'(got_q.size()), 32'(exp_q.size()));
        while (got_q.size() > 0 && exp_q.size() > 0)
            check({tag, "_data"}, 32'(got_q.pop_front()), 32'(exp_q.pop_front()));
        got_q.delete();
        exp_q.delete();
        check({tag, "_perr"}, 32'(n_perr), 32'(e_perr));
        check({tag, "_ferr"}, 32'(n_ferr), 32'(e_ferr));
        check({tag, "_ovr"}, 32'(n_ovr), 32'(e_ovr));
    endtask

    initial begin
        logic [7:0] d;
        logic [1:0] mode;
        logic       pbit;
        logic       stop;

        step(3);
        check("rst_tvalid", 32'(tvalid), 32'd0);
        check("rst_tdata", 32'(tdata), 32'd0);
        check("rst_errs", {29'd0, perr, ferr, ovr}, 32'd0);
        check("rst_state", 32'(dut.state), 32'(IDLE));
        rst = 1'b0;
        step(4);

        model_frame(8'hA5, 2'b00, 1'b0, 1'b1, 1'b0);
        send_frame(8'hA5, 2'b00, 1'b0, 1'b1, 0);
        verify("8n1");

        par = 2'b01;
        pbit = 1'b1;
        model_frame(8'h5A, 2'b01, pbit, 1'b1, 1'b0);
        send_frame(8'h5A, 2'b01, pbit, 1'b1, 0);
        verify("even_bad");
        pbit = good_parity(8'h5A, 2'b01);
        model_frame(8'h5A, 2'b01, pbit, 1'b1, 1'b0);
        send_frame(8'h5A, 2'b01, pbit, 1'b1, 0);
        verify("even_good");
        par = 2'b00;

        rx = 1'b0;
        step(3);
        rx = 1'b1;
        step(40);
        check("glitch_state", 32'(dut.state), 32'(IDLE));
        verify("glitch");

        model_frame(8'h3C, 2'b00, 1'b0, 1'b0, 1'b0);
        send_frame(8'h3C, 2'b00, 1'b0, 1'b0, 40);
        model_frame(8'h81, 2'b00, 1'b0, 1'b1, 1'b0);
        send_frame(8'h81, 2'b00, 1'b0, 1'b1, 0);
        verify("break");

        tready_set = 1'b0;
        model_frame(8'h11, 2'b00, 1'b0, 1'b1, 1'b1);
        send_frame(8'h11, 2'b00, 1'b0, 1'b1, 0);
        model_frame(8'h22, 2'b00, 1'b0, 1'b1, 1'b1);
        send_frame(8'h22, 2'b00, 1'b0, 1'b1, 0);
        check("stall_tdata", 32'(tdata), 32'h11);
        check("stall_tvalid", 32'(tvalid), 32'd1);
        check("stall_ovr", 32'(n_ovr), 32'(e_ovr));
        check("stall_nobeat", 32'(got_q.size()), 32'd0);
        tready_set = 1'b1;
        held = 1'b0;
        verify("stall");

        rx = 1'b0;
        step(16);
        rx = 1'b1;
        step(40);
        rst = 1'b1;
        #1;
        check("midrst_tvalid", 32'(tvalid), 32'd0);
        check("midrst_tdata", 32'(tdata), 32'd0);
        check("midrst_errs", {29'd0, perr, ferr, ovr}, 32'd0);
        check("midrst_state", 32'(dut.state), 32'(IDLE));
        step(3);
        rst = 1'b0;
        step(4);
        model_frame(8'h0F, 2'b00, 1'b0, 1'b1, 1'b0);
        send_frame(8'h0F, 2'b00, 1'b0, 1'b1, 0);
        verify("after_rst");

        div = 1;
        model_frame(8'hC3, 2'b00, 1'b0, 1'b1, 1'b0);
        send_frame(8'hC3, 2'b00, 1'b0, 1'b1, 0);
        div = 0;
        model_frame(8'h96, 2'b00, 1'b0, 1'b1, 1'b0);
        send_frame(8'h96, 2'b00, 1'b0, 1'b1, 0);
        verify("clamp");

        rnd_ready = 1'b1;
        for (int f = 0; f < 30; f++) begin
            div  = DIVIDER_WIDTH'($urandom_range(4, 24));
            d    = 8'($urandom_range(0, 255));
            mode = 2'($urandom_range(0, 3));
            par  = mode;
            pbit = good_parity(d, mode) ^ ($urandom_range(0, 3) == 0);
            stop = !(($urandom_range(0, 5) == 0) && (mode == 2'b00 || PAR_EN));
            model_frame(d, mode, pbit, stop, 1'b0);
            send_frame(d, mode, pbit, stop, 8 + int'($urandom_range(0, 30)));
            verify("rand");
        end
        rnd_ready = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1);
    end

endmodule

// File: doc/axis_uart_rx.md
AXIS_UART_RX -- requirements
Module: axis_uart_rx

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2: flop depth of the uart_rx_i synchronizer, min 2.
REQ-002 SHALL have port clk_i, input, 1: single clock.
REQ-003 SHALL have port rst_i, input, 1: reset, asynchronous, active-high.
REQ-004 SHALL have port uart_rx_i, input, 1: serial line, idle high, asynchronous to clk_i.
REQ-005 SHALL have port clk_divider_i, input, DIVIDER_WIDTH: clk_i cycles per bit.
REQ-006 SHALL have port parity_i, input, uart_parity_reg_t: odd/even select; both 0 = no parity bit.
REQ-007 SHALL have port m_axis_tdata_o, output, DATA_WIDTH: received byte.
REQ-008 SHALL have port m_axis_tvalid_o, output, 1: byte valid.
REQ-009 SHALL have port m_axis_tready_i, input, 1: downstream ready.
REQ-010 SHALL have ports parity_err_o, frame_err_o, overrun_o, each output, 1: one-cycle error pulses.

Function
REQ-011 SHALL synchronize uart_rx_i through SYNC_STAGES flops reset to 1; all logic uses the synchronized value.
REQ-012 SHALL use states IDLE, START, DATA, PARITY, STOP, WAIT from uart_state_e.
REQ-013 SHALL capture clk_divider_i and parity_i at start detection and hold them for the frame; a captured divider below 2 is clamped to 2.
REQ-014 IDLE->START on a synchronized 1->0 transition.
REQ-015 START SHALL sample after floor(div/2) cycles; a 1 returns to IDLE with no output (glitch reject), a 0 enters DATA.
REQ-016 DATA SHALL sample DATA_WIDTH bits LSB first, each div cycles after the previous sample.
REQ-017 After DATA: enter PARITY if odd or even is set, else STOP; odd takes precedence when both are set.
REQ-018 PARITY SHALL compare the sample with the package parity(data, mode) function; on mismatch, pulse parity_err_o and drop the byte.
REQ-019 STOP sample 1 with no parity error: byte complete, return to IDLE. Sample 0: pulse frame_err_o, drop the byte, enter WAIT.
REQ-020 WAIT SHALL stay until the synchronized line is 1, then enter IDLE (break handling).
REQ-021 Output stage is a single-entry register. The byte loads and m_axis_tvalid_o rises the cycle after the stop sample.
REQ-022 tdata/tvalid SHALL hold stable until a cycle with tvalid and tready both high.
REQ-023 If completion coincides with tvalid=1 and tready=0: pulse overrun_o, drop the new byte, keep the held byte.
REQ-024 If completion coincides with a handshake: accept the old byte and load the new one, with tvalid remaining 1 and no overrun.
REQ-025 At most one error pulse per frame; error pulses do not affect tvalid.

Reset
REQ-026 rst_i SHALL immediately force IDLE, clear counters, and set m_axis_tvalid_o=0, m_axis_tdata_o=0, all error outputs 0, synchronizer flops 1.
REQ-027 Reset mid-frame SHALL discard the partial byte; the next start requires a fresh 1->0 transition after release.

Configuration
REQ-028 Macro AXIS_UART_RX_PARITY_EN defined: PARITY state and parity_i honoured per REQ-017/018.
REQ-029 Macro AXIS_UART_RX_PARITY_EN undefined: frames are always 8N1, parity_i is ignored, the PARITY state is unreachable, and parity_err_o is tied to 0.

Structure
REQ-030 DATA_WIDTH, DIVIDER_WIDTH, uart_parity_reg_t, uart_state_e and the parity function SHALL come from axis_uart_pkg; no local duplicates.
REQ-031 One sub-module, axis_uart_sync: a SYNC_STAGES-deep flop chain with reset value 1. Baud counter and FSM stay in axis_uart_rx.

Verification
REQ-032 div=16, no parity, tready=1, send 0xA5 8N1 -> one tvalid beat with tdata=0xA5, no error pulses.
REQ-033 div=16, even parity, send 0x5A with parity bit 1 -> parity_err_o pulse, no tvalid. Resend with bit 0 -> tdata=0x5A.
REQ-034 div=16, 3-cycle low glitch on an idle line -> FSM returns to IDLE, no tvalid, no errors.
REQ-035 div=16, 0x3C with stop bit 0 and line held low 40 cycles -> frame_err_o pulse, FSM in WAIT until the line is high, then 0x81 received correctly.
REQ-036 tready=0, send 0x11 then 0x22 -> tdata stays 0x11, overrun_o pulses once; raise tready -> single beat of 0x11.
REQ-037 Assert rst_i mid-DATA of 0xFF -> all outputs 0 at once; after release, 0x0F is received correctly.
